// File: rtl/spart_rx.sv
// spart_rx: oversampled UART receiver with start-bit qualification, mid-bit
// sampling, stop-bit check and a processor-side status/data register.
module spart_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 baud_en_i,
    input  logic                 rxd_i,
    input  logic                 rx_read_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rda_o,
    output logic                 framing_err_o,
    output logic                 overrun_err_o
);

    localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CntW-1:0] HalfLast = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    logic [1:0]           sync_q;
    logic                 rxd_s;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rda_q, rda_d;
    logic                 fe_q, fe_d;
    logic                 ov_q, ov_d;

    // Two-flop synchronizer on the asynchronous serial line; idles high.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
        end
    end

    assign rxd_s = sync_q[1];

    // State, counters, shift register and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            armed_q   <= 1'b0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rda_q     <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            armed_q   <= armed_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rda_q     <= rda_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    // Next-state: receive FSM on baud ticks, status clearing on processor reads.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        armed_d   = armed_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        fe_d      = fe_q;
        ov_d      = ov_q;

        if (rx_read_i) begin
            rda_d = 1'b0;
            ov_d  = 1'b0;
        end

        if (baud_en_i) begin
            if (rxd_s) begin
                armed_d = 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    // Only a high-to-low transition after an armed idle counts as a start.
                    if (armed_q && !rxd_s) begin
                        state_d = StStart;
                        cnt_d   = '0;
                        armed_d = 1'b0;
                    end
                end
                StStart: begin
                    if (cnt_q != HalfLast) begin
                        cnt_d = cnt_q + CntW'(1);
                    end else if (!rxd_s) begin
                        state_d = StData;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        // Start bit did not survive to mid-bit: treat as a glitch.
                        state_d = StIdle;
                    end
                end
                StData: begin
                    if (cnt_q != BitLast) begin
                        cnt_d = cnt_q + CntW'(1);
                    end else begin
                        shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                        cnt_d   = '0;
                        idx_d   = idx_q + IdxW'(1);
                        if (idx_q == IdxLast) begin
                            state_d = StStop;
                        end
                    end
                end
                StStop: begin
                    if (cnt_q != BitLast) begin
                        cnt_d = cnt_q + CntW'(1);
                    end else begin
                        cnt_d     = '0;
                        state_d   = StIdle;
                        rx_data_d = shift_q;
                        rda_d     = 1'b1;
                        fe_d      = ~rxd_s;
                        // A coincident read wins: overrun stays cleared.
                        if (rda_q && !rx_read_i) begin
                            ov_d = 1'b1;
                        end
                        // A low stop bit disarms so a held-low break cannot retrigger.
                        armed_d = rxd_s;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign rx_data_o     = rx_data_q;
    assign rda_o         = rda_q;
    assign framing_err_o = fe_q;
    assign overrun_err_o = ov_q;

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: frame-level reference model, directed
// scenarios and randomized frames with random read behaviour.
module tb_spart_rx;

    localparam int BitClk = 64;  // 16 baud ticks x 4 clk per tick

    logic       clk;
    logic       rst_n;
    logic       baud_en;
    logic       rxd;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun_err;

    int tests_run;
    int tests_failed;
    int bcnt;

    // Reference model of the processor-visible register state.
    logic [7:0] exp_data;
    logic       exp_rda;
    logic       exp_fe;
    logic       exp_ov;

    spart_rx #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .baud_en_i    (baud_en),
        .rxd_i        (rxd),
        .rx_read_i    (rx_read),
        .rx_data_o    (rx_data),
        .rda_o        (rda),
        .framing_err_o(framing_err),
        .overrun_err_o(overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud enable: one clk high every 4 clks, updated on the falling edge.
    initial begin
        baud_en = 1'b0;
        bcnt    = 0;
        forever begin
            @(negedge clk);
            baud_en = (bcnt == 0);
            bcnt    = (bcnt + 1) % 4;
        end
    end

    task automatic model_reset();
        exp_data = 8'h00;
        exp_rda  = 1'b0;
        exp_fe   = 1'b0;
        exp_ov   = 1'b0;
    endtask

    // Send one frame aligned just after a baud tick. With rd_at_done the read strobe
    // lands on the stop-sample edge: 1 tick detection + 152 ticks = 612 clk later.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rd_at_done);
        do @(posedge clk); while (!baud_en);
        @(negedge clk);
        rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BitClk) @(negedge clk);
            rxd = b[i];
        end
        repeat (BitClk) @(negedge clk);
        rxd = stop;
        if (rd_at_done) begin
            repeat (35) @(negedge clk);
            rx_read = 1'b1;
            @(negedge clk);
            rx_read = 1'b0;
            repeat (28) @(negedge clk);
        end else begin
            repeat (BitClk) @(negedge clk);
        end
        if (rd_at_done) exp_ov = 1'b0;
        else if (exp_rda) exp_ov = 1'b1;
        exp_data = b;
        exp_rda  = 1'b1;
        exp_fe   = ~stop;
    endtask

    task automatic pulse_read();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
        exp_rda = 1'b0;
        exp_ov  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        tests_run += 4;
        if (rx_data !== 8'h00) begin
            tests_failed++; $display("FAIL reset_data: got %h want 00", rx_data);
        end
        if (rda !== 1'b0) begin
            tests_failed++; $display("FAIL reset_rda: got %b want 0", rda);
        end
        if (framing_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_fe: got %b want 0", framing_err);
        end
        if (overrun_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ov: got %b want 0", overrun_err);
        end
    endtask

    task automatic test_basic();
        repeat (2 * BitClk) @(negedge clk);
        send_frame(8'hA5, 1'b1, 1'b0);
        tests_run += 4;
        if (rx_data !== exp_data) begin
            tests_failed++; $display("FAIL basic_data: got %h want %h", rx_data, exp_data);
        end
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL basic_rda: got %b want %b", rda, exp_rda);
        end
        if (framing_err !== exp_fe) begin
            tests_failed++; $display("FAIL basic_fe: got %b want %b", framing_err, exp_fe);
        end
        if (overrun_err !== exp_ov) begin
            tests_failed++; $display("FAIL basic_ov: got %b want %b", overrun_err, exp_ov);
        end
        pulse_read();
        tests_run += 2;
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL basic_read_rda: got %b want %b", rda, exp_rda);
        end
        if (rx_data !== exp_data) begin
            tests_failed++; $display("FAIL basic_read_data: got %h want %h", rx_data, exp_data);
        end
    endtask

    task automatic test_glitch();
        do @(posedge clk); while (!baud_en);
        @(negedge clk);
        rxd = 1'b0;
        repeat (12) @(negedge clk);  // low for three baud ticks
        rxd = 1'b1;
        repeat (3 * BitClk) @(negedge clk);
        tests_run += 2;
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL glitch_rda: got %b want %b", rda, exp_rda);
        end
        if (rx_data !== exp_data) begin
            tests_failed++; $display("FAIL glitch_data: got %h want %h", rx_data, exp_data);
        end
        send_frame(8'h5A, 1'b1, 1'b0);
        tests_run += 2;
        if (rx_data !== exp_data) begin
            tests_failed++; $display("FAIL glitch_next_data: got %h want %h", rx_data, exp_data);
        end
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL glitch_next_rda: got %b want %b", rda, exp_rda);
        end
        pulse_read();
    endtask

    task automatic test_framing_break();
        send_frame(8'h3C, 1'b0, 1'b0);  // line stays low afterwards
        tests_run += 2;
        if (rx_data !== exp_data) begin
            tests_failed++; $display("FAIL break_data: got %h want %h", rx_data, exp_data);
        end
        if (framing_err !== exp_fe) begin
            tests_failed++; $display("FAIL break_fe: got %b want %b", framing_err, exp_fe);
        end
        pulse_read();
        repeat (40 * BitClk) @(negedge clk);
        tests_run += 2;
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL break_no_rda: got %b want %b", rda, exp_rda);
        end
        if (framing_err !== exp_fe) begin
            tests_failed++; $display("FAIL break_fe_hold: got %b want %b", framing_err, exp_fe);
        end
        rxd = 1'b1;
        repeat (BitClk) @(negedge clk);
        send_frame(8'h0F, 1'b1, 1'b0);
        tests_run += 3;
        if (rx_data !== exp_data) begin
            tests_failed++; $display("FAIL break_next_data: got %h want %h", rx_data, exp_data);
        end
        if (framing_err !== exp_fe) begin
            tests_failed++; $display("FAIL break_next_fe: got %b want %b", framing_err, exp_fe);
        end
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL break_next_rda: got %b want %b", rda, exp_rda);
        end
        pulse_read();
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        tests_run += 3;
        if (rx_data !== exp_data) begin
            tests_failed++; $display("FAIL b2b_data: got %h want %h", rx_data, exp_data);
        end
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL b2b_rda: got %b want %b", rda, exp_rda);
        end
        if (overrun_err !== exp_ov) begin
            tests_failed++; $display("FAIL b2b_ov: got %b want %b", overrun_err, exp_ov);
        end
        pulse_read();
        tests_run += 2;
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL b2b_read_rda: got %b want %b", rda, exp_rda);
        end
        if (overrun_err !== exp_ov) begin
            tests_failed++; $display("FAIL b2b_read_ov: got %b want %b", overrun_err, exp_ov);
        end
    endtask

    task automatic test_read_at_completion();
        // Build up an overrun first so the coincident read must also clear it.
        send_frame(8'h44, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h77, 1'b1, 1'b1);
        tests_run += 3;
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL coinc_rda: got %b want %b", rda, exp_rda);
        end
        if (rx_data !== exp_data) begin
            tests_failed++; $display("FAIL coinc_data: got %h want %h", rx_data, exp_data);
        end
        if (overrun_err !== exp_ov) begin
            tests_failed++; $display("FAIL coinc_ov: got %b want %b", overrun_err, exp_ov);
        end
    endtask

    task automatic test_reset_midframe();
        do @(posedge clk); while (!baud_en);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BitClk) @(negedge clk);
        rxd = 1'b1;  // 0xFF: all data bits high
        repeat (4 * BitClk + 20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tests_run += 4;
        if (rx_data !== exp_data) begin
            tests_failed++; $display("FAIL midrst_data: got %h want %h", rx_data, exp_data);
        end
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL midrst_rda: got %b want %b", rda, exp_rda);
        end
        if (framing_err !== exp_fe) begin
            tests_failed++; $display("FAIL midrst_fe: got %b want %b", framing_err, exp_fe);
        end
        if (overrun_err !== exp_ov) begin
            tests_failed++; $display("FAIL midrst_ov: got %b want %b", overrun_err, exp_ov);
        end
        repeat (5 * BitClk) @(negedge clk);
        tests_run += 1;
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL midrst_quiet_rda: got %b want %b", rda, exp_rda);
        end
        send_frame(8'h81, 1'b1, 1'b0);
        tests_run += 3;
        if (rx_data !== exp_data) begin
            tests_failed++; $display("FAIL midrst_next_data: got %h want %h", rx_data, exp_data);
        end
        if (rda !== exp_rda) begin
            tests_failed++; $display("FAIL midrst_next_rda: got %b want %b", rda, exp_rda);
        end
        if (framing_err !== exp_fe) begin
            tests_failed++; $display("FAIL midrst_next_fe: got %b want %b", framing_err, exp_fe);
        end
        pulse_read();
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       stop;
        int         mode;
        for (int n = 0; n < 16; n++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 2);
            if (rxd !== 1'b1) begin
                rxd = 1'b1;
                repeat (BitClk) @(negedge clk);
            end
            repeat ($urandom_range(0, 100)) @(negedge clk);
            send_frame(b, stop, (mode == 1));
            if (mode == 2) pulse_read();
            tests_run += 4;
            if (rx_data !== exp_data) begin
                tests_failed++; $display("FAIL rand%0d_data: got %h want %h", n, rx_data, exp_data);
            end
            if (rda !== exp_rda) begin
                tests_failed++; $display("FAIL rand%0d_rda: got %b want %b", n, rda, exp_rda);
            end
            if (framing_err !== exp_fe) begin
                tests_failed++; $display("FAIL rand%0d_fe: got %b want %b", n, framing_err, exp_fe);
            end
            if (overrun_err !== exp_ov) begin
                tests_failed++; $display("FAIL rand%0d_ov: got %b want %b", n, overrun_err, exp_ov);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        rxd          = 1'b1;
        rx_read      = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_glitch();
        test_framing_break();
        test_back_to_back();
        test_read_at_completion();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spart_rx.md
# spart_rx

Serial receive half of the SPART. Consumes the 16x-oversampled enable pulse from the baud generator, synchronizes the asynchronous RxD line, and locates the start bit. It samples each of 8 data bits (LSB first) at mid-bit and checks the stop bit. The received byte is presented to the processor-side bus interface with a receive-data-available flag and error status.

## Interface
- OVERSAMPLE, 16: baud_en pulses per bit time; must be even, ≥4.
- DATA_BITS, 8: data bits per frame.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- baud_en  in  1  one-clk-wide pulse at OVERSAMPLE × baud rate, from the baud generator.
- rxd  in  1  asynchronous serial input; idles high.
- rx_read  in  1  one-cycle strobe; the processor has read rx_data.
- rx_data  out  DATA_BITS  last complete received byte.
- rda  out  1  receive data available.
- framing_err  out  1  stop bit of the byte in rx_data sampled low.
- overrun_err  out  1  a byte was overwritten while unread; sticky.

## Operation
- Synchronizer: two flops on rxd produce rxd_s. Reset value 1. Latency 2 clk. All decisions use rxd_s only.
- Counters: cnt (log2 OVERSAMPLE bits) and bit_idx (log2 DATA_BITS bits).
- Counters, FSM and shift register advance only on clk edges with baud_en=1. With baud_en=0 they hold.
- armed flag: set on any baud_en with rxd_s=1. Cleared on start detection.
- FSM states and transitions (all on baud_en=1):
  - IDLE: if armed and rxd_s=0, go to START with cnt←0 and armed←0.
  - START:
    - If cnt≠OVERSAMPLE/2−1, cnt←cnt+1.
    - Otherwise, this is the mid-start sample (8th tick after detection):
      - rxd_s=0: go to DATA, cnt←0, bit_idx←0.
      - rxd_s=1: glitch; go to IDLE with no output change.
  - DATA:
    - If cnt≠OVERSAMPLE−1, cnt←cnt+1.
    - Otherwise, shift rxd_s into shift[DATA_BITS−1] (right shift, LSB first), cnt←0, bit_idx←bit_idx+1.
    - After the sample with bit_idx=DATA_BITS−1, go to STOP.
  - STOP: on cnt=OVERSAMPLE−1, perform the completion update, cnt←0, go to IDLE.
- Completion update:
  - rx_data←shift; rda←1; framing_err←~rxd_s.
  - overrun_err←1 if rda=1 and rx_read=0 in that cycle.
- Framing error recovery: a low stop bit leaves armed=0. No new start is detected until rxd_s=1 has been seen on a baud_en, so a break condition cannot retrigger reception.
- rx_read:
  - Clears rda and overrun_err on the next edge.
  - rx_data and framing_err hold their values.
  - If rx_read coincides with a completion update, the completion wins: rda stays 1 with the new byte, overrun_err is not set, and any previously set overrun_err is cleared.
- rx_read while rda=0 has no effect.

## Timing
- Reset values: rx_data=0, rda=0, framing_err=0, overrun_err=0, state IDLE, cnt=0, bit_idx=0, armed=0, sync flops=1.
- Reset mid-frame aborts the frame without output update. The first frame after reset needs rxd_s high on one baud_en to arm.
- Sample points after the detection tick: OVERSAMPLE/2, then +OVERSAMPLE per bit. The stop bit is sampled at OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE ticks.
- Outputs are registered. rda, rx_data and framing_err change on the clk edge of the stop-sample baud_en and are visible the following cycle.
- Start detection uncertainty is ≤1 baud_en period plus 2 clk of synchronizer delay.
- A back-to-back next start bit is accepted on the first baud_en in IDLE after completion.

## Test plan
- Reset, idle high, then frame 0xA5 (baud_en every 4 clk, 64 clk/bit) → rda=1, rx_data=0xA5, framing_err=0, overrun_err=0; rx_read → rda=0 next cycle.
- rxd low for 3 baud_en ticks then high → FSM returns to IDLE, rda stays 0. A following 0x5A frame is received correctly.
- Frame 0x3C with stop bit 0, then line held low for 40 bit times → rx_data=0x3C, framing_err=1, no further rda. Line high, then frame 0x0F → rx_data=0x0F, framing_err=0.
- Frames 0x11 then 0x22 back-to-back with no rx_read → rx_data=0x22, rda=1, overrun_err=1. rx_read → rda=0, overrun_err=0.
- rx_read asserted in exactly the completion cycle of a second frame 0x77 → rda=1, rx_data=0x77, overrun_err=0.
- rst_n low for 1 clk during bit 4 of frame 0xFF → all outputs 0. The next frame 0x81 is received correctly.
